// File: rtl/nmos_lpen_pkg.sv
// nmos_lpen_pkg: shared types and constants for the light-pen controller.
//   state_t : trigger sequencer state encoding (2 bits)
//   CNT_W   : width of the pen-low filter counter
package nmos_lpen_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_FILTER = 2'd1,
        ST_LOAD   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

endpackage : nmos_lpen_pkg

// File: rtl/nmos_sync2.sv
// nmos_sync2: two-flop synchroniser for an asynchronous pin; both stages
// reset to 1 (inactive level for active-low pins).
//   i_clk : sampling clock
//   i_rst : synchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronised output (second stage)
module nmos_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule : nmos_sync2

// File: rtl/nmos_lpen_ctrl.sv
// nmos_lpen_ctrl: light-pen controller. Synchronises and filters the pen pin,
// gates the first low sample with a vertical line window, allows one latch
// load per frame and drives the H/V latch-slice strobes and read controls.
// Optional interrupt flag is built when LPEN_IRQ_EN is defined; otherwise IRQ
// is tied low and IRQ_ACK is ignored.
//   main_clk, main_rst : clock, synchronous active-high reset
//   LP_N               : asynchronous pen pin, active low
//   VSTRT              : one-cycle frame-start pulse
//   VPOS               : current beam line
//   RD_H, RD_V         : CPU read selects for the H / V latch register
//   IRQ_ACK            : interrupt acknowledge
//   LPLD_H, LPLD_V     : one-cycle load strobes to the latch slices
//   LPRD_H, LPRD_V     : latch read select (1 = latched, 0 = live counter)
//   OE_H, OE_V         : bus drive enables
//   LP_HIT             : a trigger was latched in this frame
//   IRQ                : light-pen interrupt request
module nmos_lpen_ctrl
    import nmos_lpen_pkg::*;
#(
    parameter int unsigned VW    = 9,
    parameter int unsigned V_MIN = 0,
    parameter int unsigned V_MAX = 311,
    parameter int unsigned FILT  = 3
) (
    input  logic          main_clk,
    input  logic          main_rst,
    input  logic          LP_N,
    input  logic          VSTRT,
    input  logic [VW-1:0] VPOS,
    input  logic          RD_H,
    input  logic          RD_V,
    input  logic          IRQ_ACK,
    output logic          LPLD_H,
    output logic          LPLD_V,
    output logic          LPRD_H,
    output logic          LPRD_V,
    output logic          OE_H,
    output logic          OE_V,
    output logic          LP_HIT,
    output logic          IRQ
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_hit;
    logic               w_pen_s2;
    logic               w_ge_min;
    logic               w_le_max;
    logic               w_in_win;
    logic               w_load;

    // Pen pin synchroniser.
    nmos_sync2 u_sync (
        .i_clk (main_clk),
        .i_rst (main_rst),
        .i_d   (LP_N),
        .o_q   (w_pen_s2)
    );

    // Window bounds; a bound at the edge of the VPOS range is always met.
    generate
        if (V_MIN == 0) begin : g_min_open
            assign w_ge_min = 1'b1;
        end else begin : g_min_cmp
            assign w_ge_min = (VPOS >= VW'(V_MIN));
        end
        if (V_MAX >= (2 ** VW) - 1) begin : g_max_open
            assign w_le_max = 1'b1;
        end else begin : g_max_cmp
            assign w_le_max = (VPOS <= VW'(V_MAX));
        end
    endgenerate

    assign w_in_win = w_ge_min & w_le_max;
    assign w_load   = (r_state == ST_LOAD);

    // State and filter-count registers.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Trigger sequencing; frame start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARMED: begin
                if (!w_pen_s2 && w_in_win) begin
                    if (FILT == 1) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_FILTER;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_FILTER: begin
                if (w_pen_s2) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(FILT - 1)) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                w_state_nxt = ST_LOCKED;
            end
            default: begin
                w_state_nxt = ST_ARMED;
                w_cnt_nxt   = '0;
            end
        endcase
        if (VSTRT) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
        end
    end

    // Hit flag: set leaving LOAD unless a new frame starts on that edge.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_hit <= 1'b0;
        end else if (VSTRT) begin
            r_hit <= 1'b0;
        end else if (w_load) begin
            r_hit <= 1'b1;
        end
    end

`ifdef LPEN_IRQ_EN
    logic r_irq;

    // Interrupt flag survives frame start; a set beats a same-cycle ack.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_irq <= 1'b0;
        end else if (w_load) begin
            r_irq <= 1'b1;
        end else if (IRQ_ACK) begin
            r_irq <= 1'b0;
        end
    end

    assign IRQ = r_irq;
`else
    logic w_unused_irq_ack;
    assign w_unused_irq_ack = IRQ_ACK;
    assign IRQ              = 1'b0;
`endif

    assign LPLD_H = w_load;
    assign LPLD_V = w_load;
    assign LP_HIT = r_hit;

    // A read during the load cycle shows the live counter, equal to the
    // value being captured.
    assign OE_H   = RD_H;
    assign OE_V   = RD_V;
    assign LPRD_H = RD_H & ~w_load;
    assign LPRD_V = RD_V & ~w_load;

endmodule : nmos_lpen_ctrl

// File: tb/tb_nmos_lpen_ctrl.sv
module tb_nmos_lpen_ctrl;

    localparam int VW    = 9;
    localparam int V_MIN = 0;
    localparam int V_MAX = 311;
    localparam int FILT  = 3;
    localparam int NVEC  = 20;

    logic          main_clk;
    logic          main_rst;
    logic          LP_N;
    logic          VSTRT;
    logic [VW-1:0] VPOS;
    logic          RD_H;
    logic          RD_V;
    logic          IRQ_ACK;
    logic          LPLD_H;
    logic          LPLD_V;
    logic          LPRD_H;
    logic          LPRD_V;
    logic          OE_H;
    logic          OE_V;
    logic          LP_HIT;
    logic          IRQ;

    int total;
    int bad;
    int pulses;

    // Reference model state: pen pipeline, run length of qualified low
    // samples, per-frame lockout, strobe, hit and irq flags.
    logic m_hist [2];
    int   m_run;
    logic m_locked;
    logic m_ld;
    logic m_hit;
    logic m_irq;

    typedef struct {
        logic          lp_n;
        logic          rst;
        logic [VW-1:0] vpos;
        logic          rd_h;
        logic          exp_oe_h;
        logic          exp_lprd_h;
        logic          exp_lpld;
        logic          exp_hit;
    } vec_t;

    vec_t tv [NVEC];

    nmos_lpen_ctrl #(
        .VW    (VW),
        .V_MIN (V_MIN),
        .V_MAX (V_MAX),
        .FILT  (FILT)
    ) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .LP_N     (LP_N),
        .VSTRT    (VSTRT),
        .VPOS     (VPOS),
        .RD_H     (RD_H),
        .RD_V     (RD_V),
        .IRQ_ACK  (IRQ_ACK),
        .LPLD_H   (LPLD_H),
        .LPLD_V   (LPLD_V),
        .LPRD_H   (LPRD_H),
        .LPRD_V   (LPRD_V),
        .OE_H     (OE_H),
        .OE_V     (OE_V),
        .LP_HIT   (LP_HIT),
        .IRQ      (IRQ)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist[0] = 1'b1;
        m_hist[1] = 1'b1;
        m_run     = 0;
        m_locked  = 1'b0;
        m_ld      = 1'b0;
        m_hit     = 1'b0;
        m_irq     = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using the current inputs.
    task automatic model_step();
        logic s2;
        bit   in_win;
        s2        = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = LP_N;
        in_win    = (int'(VPOS) >= V_MIN) && (int'(VPOS) <= V_MAX);
        if (main_rst) begin
            model_reset();
        end else begin
            if (m_ld) m_irq = 1'b1;
            else if (IRQ_ACK) m_irq = 1'b0;
            if (VSTRT) begin
                m_run    = 0;
                m_locked = 1'b0;
                m_hit    = 1'b0;
                m_ld     = 1'b0;
            end else if (m_ld) begin
                m_locked = 1'b1;
                m_hit    = 1'b1;
                m_ld     = 1'b0;
            end else if (!m_locked) begin
                if (!s2 && (m_run > 0 || in_win)) m_run++;
                else m_run = 0;
                if (m_run == FILT) begin
                    m_ld  = 1'b1;
                    m_run = 0;
                end
            end
        end
    endtask

    // Combinational bus-control checks for the inputs now applied.
    task automatic tick_pre();
        #1;
        check("oe_h", OE_H, RD_H);
        check("oe_v", OE_V, RD_V);
        check("lprd_h", LPRD_H, RD_H & ~m_ld);
        check("lprd_v", LPRD_V, RD_V & ~m_ld);
    endtask

    // Clock edge, model update and registered-output checks.
    task automatic tick_post();
        @(posedge main_clk);
        model_step();
        #1;
        check("lpld_h", LPLD_H, m_ld);
        check("lpld_v", LPLD_V, m_ld);
        check("lp_hit", LP_HIT, m_hit);
`ifdef LPEN_IRQ_EN
        check("irq", IRQ, m_irq);
`else
        check("irq", IRQ, 1'b0);
`endif
        if (LPLD_H === 1'b1) pulses++;
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    initial begin
        bit got_ld;
        total    = 0;
        bad      = 0;
        pulses   = 0;
        main_rst = 1'b1;
        LP_N     = 1'b1;
        VSTRT    = 1'b0;
        VPOS     = VW'(100);
        RD_H     = 1'b0;
        RD_V     = 1'b0;
        IRQ_ACK  = 1'b0;
        model_reset();

        // Row r drives the cycle ending at edge r+1; pen low from edge 10.
        for (int r = 0; r < NVEC; r++) begin
            tv[r].rst        = (r < 2);
            tv[r].lp_n       = (r >= 9) ? 1'b0 : 1'b1;
            tv[r].vpos       = VW'(100);
            tv[r].rd_h       = (r == 14 || r == 15);
            tv[r].exp_oe_h   = (r == 14 || r == 15);
            tv[r].exp_lprd_h = (r == 15);
            tv[r].exp_lpld   = (r == 13);
            tv[r].exp_hit    = (r >= 14);
        end

        for (int r = 0; r < NVEC; r++) begin
            main_rst = tv[r].rst;
            LP_N     = tv[r].lp_n;
            VPOS     = tv[r].vpos;
            RD_H     = tv[r].rd_h;
            tick_pre();
            check("tv_oe_h", OE_H, tv[r].exp_oe_h);
            check("tv_lprd_h", LPRD_H, tv[r].exp_lprd_h);
            tick_post();
            check("tv_lpld", LPLD_H, tv[r].exp_lpld);
            check("tv_hit", LP_HIT, tv[r].exp_hit);
        end
        RD_H = 1'b0;

        // Short pen pulse (2 samples) aborts in the filter.
        LP_N  = 1'b1;
        VSTRT = 1'b1;
        tick();
        VSTRT = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        pulses = 0;
        LP_N   = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        LP_N = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_int("abort_pulses", pulses, 0);

        // Out-of-window start: nothing until the next frame's in-window line.
        VPOS   = VW'(V_MAX + 1);
        LP_N   = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) tick();
        check_int("outwin_pulses", pulses, 0);
        VSTRT = 1'b1;
        VPOS  = VW'(0);
        tick();
        VSTRT = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_int("nextframe_pulses", pulses, 1);

        // Pen held low across three frames: one strobe per frame.
        VPOS   = VW'(50);
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            VSTRT = 1'b1;
            tick();
            VSTRT = 1'b0;
            for (int i = 0; i < 10; i++) tick();
        end
        check_int("frames_pulses", pulses, 3);

        // Frame start coinciding with the load cycle: hit must stay clear.
        VSTRT = 1'b1;
        tick();
        VSTRT  = 1'b0;
        got_ld = 1'b0;
        for (int i = 0; i < 10 && !got_ld; i++) begin
            tick();
            got_ld = m_ld;
        end
        check("ld_reached", got_ld, 1'b1);
        VSTRT = 1'b1;
        tick();
        VSTRT = 1'b0;
        check("hit_vstrt_load", LP_HIT, 1'b0);

        // Reset in the middle of filtering: no strobe shortly after.
        VSTRT = 1'b1;
        tick();
        VSTRT = 1'b0;
        tick();
        main_rst = 1'b1;
        tick();
        main_rst = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 2; i++) tick();
        check_int("rst_pulses", pulses, 0);
        check("rst_hit", LP_HIT, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) LP_N = ~LP_N;
            VSTRT    = ($urandom_range(0, 39) == 0);
            main_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) VPOS = VW'($urandom_range(0, 340));
            RD_H     = 1'($urandom_range(0, 1));
            RD_V     = 1'($urandom_range(0, 1));
            IRQ_ACK  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nmos_lpen_ctrl
